cellrv32_icache_mem: RTL and testbench

// - Storage array for the CELLRV32 i-cache: data words, per-word error status, tags, valid bits, LRU state.
// - Instantiated by the i-cache controller FSM.
//   - Host port: read-only lookup, registered.
//   - Ctrl port: write-only, used for block refill.
// - Direct-mapped or 2-way set-associative.

---
 rtl/cellrv32_package.sv | 33 +++
 rtl/cellrv32_icache_mem_if.sv | 30 +++
 rtl/cellrv32_icache_way.sv | 52 +++++
 rtl/cellrv32_icache_mem.sv | 112 +++++++++++
 tb/tb_cellrv32_icache_mem.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/cellrv32_package.sv
// Shared geometry helpers for the CELLRV32 i-cache storage array.
// The optional define CELLRV32_ICACHE_LRU_EN is consumed by cellrv32_icache_mem.
package cellrv32_package;

    function automatic bit is_power_of_two_f(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    function automatic int off_width_f(input int block_size);
        return $clog2(block_size / 4);
    endfunction

    function automatic int idx_width_f(input int num_blocks);
        return $clog2(num_blocks);
    endfunction

    function automatic int tag_width_f(input int block_size, input int num_blocks);
        return 32 - off_width_f(block_size) - idx_width_f(num_blocks) - 2;
    endfunction

    // Address layout for the default geometry (4 blocks of 64 bytes).
    localparam int OFF_DEF = off_width_f(64);
    localparam int IDX_DEF = idx_width_f(4);
    localparam int TAG_DEF = tag_width_f(64, 4);

    typedef struct packed {
        logic [TAG_DEF-1:0] tag;
        logic [IDX_DEF-1:0] index;
        logic [OFF_DEF-1:0] word;
        logic [1:0]         byte_off;
    } cache_addr_t;

endpackage

// File: rtl/cellrv32_icache_mem_if.sv
// Host lookup and controller refill signals of the i-cache storage array.
// valid/ready does not apply: host_re_i and ctrl_* are single-cycle strobes, results follow one edge later.
interface cellrv32_icache_mem_if;
    logic        invalidate_i;
    logic [31:0] host_addr_i;
    logic        host_re_i;
    logic [31:0] host_rdata_o;
    logic        host_rstat_o;
    logic        hit_o;
    logic        ctrl_en_i;
    logic [31:0] ctrl_addr_i;
    logic        ctrl_we_i;
    logic [31:0] ctrl_wdata_i;
    logic        ctrl_wstat_i;
    logic        ctrl_tag_we_i;
    logic        ctrl_valid_i;
    logic        ctrl_invalid_i;

    modport master (
        output invalidate_i, host_addr_i, host_re_i, ctrl_en_i, ctrl_addr_i, ctrl_we_i,
               ctrl_wdata_i, ctrl_wstat_i, ctrl_tag_we_i, ctrl_valid_i, ctrl_invalid_i,
        input  host_rdata_o, host_rstat_o, hit_o
    );

    modport slave (
        input  invalidate_i, host_addr_i, host_re_i, ctrl_en_i, ctrl_addr_i, ctrl_we_i,
               ctrl_wdata_i, ctrl_wstat_i, ctrl_tag_we_i, ctrl_valid_i, ctrl_invalid_i,
        output host_rdata_o, host_rstat_o, hit_o
    );
endinterface

// File: rtl/cellrv32_icache_way.sv
// One way of the i-cache: data/status words, tags and valid bits.
// Data is read synchronously; hit is evaluated against the registered lookup address.
module cellrv32_icache_way #(
    parameter int NUM_BLOCKS = 4,
    parameter int WORDS      = 16,
    parameter int IDX_B      = 2,
    parameter int OFF_B      = 4,
    parameter int TAG_W      = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_all,
    input  logic [IDX_B-1:0] acc_index,
    input  logic [OFF_B-1:0] acc_word,
    input  logic             we,
    input  logic [IDX_B-1:0] wr_index,
    input  logic [OFF_B-1:0] wr_word,
    input  logic [32:0]      wdata,
    input  logic             tag_we,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             set_valid,
    input  logic             clr_valid,
    input  logic [IDX_B-1:0] lk_index,
    input  logic [TAG_W-1:0] lk_tag,
    output logic [32:0]      rdata,
    output logic             hit
);

    logic [32:0]      data_mem [NUM_BLOCKS][WORDS];
    logic [TAG_W-1:0] tag_mem  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] valid;

    always_ff @(posedge clk) begin
        if (we) data_mem[wr_index][wr_word] <= wdata;
        if (tag_we) tag_mem[wr_index] <= wr_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else     rdata <= data_mem[acc_index][acc_word];
    end

    // Invalidate beats any per-block update in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clr_all)  valid <= '0;
        else if (set_valid)  valid[wr_index] <= 1'b1;
        else if (clr_valid)  valid[wr_index] <= 1'b0;
    end

    assign hit = valid[lk_index] && (tag_mem[lk_index] == lk_tag);

endmodule

// File: rtl/cellrv32_icache_mem.sv
// CELLRV32 i-cache storage array: direct-mapped or 2-way, registered host lookup.
// Define CELLRV32_ICACHE_LRU_EN for LRU replacement; otherwise 2-way uses a global round-robin bit.
import cellrv32_package::*;

module cellrv32_icache_mem #(
    parameter int ICACHE_NUM_BLOCKS = 4,
    parameter int ICACHE_BLOCK_SIZE = 64,
    parameter int ICACHE_NUM_SETS   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    cellrv32_icache_mem_if.slave bus
);

    localparam int OFF   = off_width_f(ICACHE_BLOCK_SIZE);
    localparam int IDX   = idx_width_f(ICACHE_NUM_BLOCKS);
    localparam int TAG_W = tag_width_f(ICACHE_BLOCK_SIZE, ICACHE_NUM_BLOCKS);
    localparam int OFF_B = (OFF > 0) ? OFF : 1;
    localparam int IDX_B = (IDX > 0) ? IDX : 1;
    localparam logic [OFF_B-1:0] OFF_MASK = (OFF > 0) ? '1 : '0;
    localparam logic [IDX_B-1:0] IDX_MASK = (IDX > 0) ? '1 : '0;

    if (!is_power_of_two_f(ICACHE_NUM_BLOCKS) || !is_power_of_two_f(ICACHE_BLOCK_SIZE) ||
        (ICACHE_BLOCK_SIZE < 4) || !((ICACHE_NUM_SETS == 1) || (ICACHE_NUM_SETS == 2))) begin : g_bad_cfg
        $error("cellrv32_icache_mem: invalid cache geometry");
    end

    logic [31:0]      acc;
    logic [IDX_B-1:0] acc_index, c_index, lk_index;
    logic [OFF_B-1:0] acc_word, c_word;
    logic [TAG_W-1:0] acc_tag, c_tag, lk_tag;
    logic             sel_set;
    logic             hit_set;
    logic [ICACHE_NUM_SETS-1:0] hits;
    logic [32:0]      rd [ICACHE_NUM_SETS];

    // Masks keep zero-width fields at zero for single-block or single-word geometries.
    assign acc       = bus.ctrl_en_i ? bus.ctrl_addr_i : bus.host_addr_i;
    assign acc_index = acc[OFF+IDX_B+1:OFF+2] & IDX_MASK;
    assign acc_word  = acc[OFF_B+1:2] & OFF_MASK;
    assign acc_tag   = acc[31:OFF+IDX+2];
    assign c_index   = bus.ctrl_addr_i[OFF+IDX_B+1:OFF+2] & IDX_MASK;
    assign c_word    = bus.ctrl_addr_i[OFF_B+1:2] & OFF_MASK;
    assign c_tag     = bus.ctrl_addr_i[31:OFF+IDX+2];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lk_index <= '0;
            lk_tag   <= '0;
        end else begin
            lk_index <= acc_index;
            lk_tag   <= acc_tag;
        end
    end

    for (genvar s = 0; s < ICACHE_NUM_SETS; s++) begin : g_way
        cellrv32_icache_way #(
            .NUM_BLOCKS(ICACHE_NUM_BLOCKS), .WORDS(ICACHE_BLOCK_SIZE / 4),
            .IDX_B(IDX_B), .OFF_B(OFF_B), .TAG_W(TAG_W)
        ) u_way (
            .clk       (clk_i),
            .rst       (rst_i),
            .clr_all   (bus.invalidate_i),
            .acc_index (acc_index),
            .acc_word  (acc_word),
            .we        (bus.ctrl_we_i && (sel_set == 1'(s))),
            .wr_index  (c_index),
            .wr_word   (c_word),
            .wdata     ({bus.ctrl_wstat_i, bus.ctrl_wdata_i}),
            .tag_we    (bus.ctrl_tag_we_i && (sel_set == 1'(s))),
            .wr_tag    (c_tag),
            .set_valid (bus.ctrl_valid_i && (sel_set == 1'(s))),
            .clr_valid (bus.ctrl_invalid_i && (sel_set == 1'(s))),
            .lk_index  (lk_index),
            .lk_tag    (lk_tag),
            .rdata     (rd[s]),
            .hit       (hits[s])
        );
    end

    assign hit_set    = (ICACHE_NUM_SETS == 2) ? hits[ICACHE_NUM_SETS-1] : 1'b0;
    assign bus.hit_o  = |hits;
    assign {bus.host_rstat_o, bus.host_rdata_o} = hit_set ? rd[ICACHE_NUM_SETS-1] : rd[0];

    if (ICACHE_NUM_SETS == 1) begin : g_dm
        assign sel_set = 1'b0;
    end else begin : g_2way
`ifdef CELLRV32_ICACHE_LRU_EN
        logic                         re_ff;
        logic [ICACHE_NUM_BLOCKS-1:0] lru;

        // lru holds the most recently used way; the victim is the other one.
        always_ff @(posedge clk_i) begin
            if (rst_i) re_ff <= 1'b0;
            else       re_ff <= bus.host_re_i;
            if (rst_i || bus.invalidate_i) lru <= '0;
            else if (bus.ctrl_valid_i) lru[c_index] <= sel_set;
            else if (re_ff && bus.hit_o && !bus.ctrl_en_i) lru[lk_index] <= hit_set;
        end
        assign sel_set = ~lru[c_index];
`else
        logic rr;

        always_ff @(posedge clk_i) begin
            if (rst_i || bus.invalidate_i) rr <= 1'b0;
            else if (bus.ctrl_valid_i)     rr <= ~rr;
        end
        assign sel_set = rr;
`endif
    end

endmodule

// File: tb/tb_cellrv32_icache_mem.sv
// Bench for cellrv32_icache_mem: drives a direct-mapped and a 2-way instance with the same stimulus.
// Expectations for the 2-way replacement case depend on CELLRV32_ICACHE_LRU_EN.
module tb_cellrv32_icache_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        invalidate = 1'b0;
  logic [31:0] host_addr = '0;
  logic        host_re = 1'b0;
  logic        ctrl_en = 1'b0;
  logic [31:0] ctrl_addr = '0;
  logic        ctrl_we = 1'b0;
  logic [31:0] ctrl_wdata = '0;
  logic        ctrl_wstat = 1'b0;
  logic        ctrl_tag_we = 1'b0;
  logic        ctrl_valid = 1'b0;
  logic        ctrl_invalid = 1'b0;

  int checks = 0;
  int failures = 0;

  cellrv32_icache_mem_if dm_if ();
  cellrv32_icache_mem_if tw_if ();

  assign dm_if.invalidate_i   = invalidate;
  assign dm_if.host_addr_i    = host_addr;
  assign dm_if.host_re_i      = host_re;
  assign dm_if.ctrl_en_i      = ctrl_en;
  assign dm_if.ctrl_addr_i    = ctrl_addr;
  assign dm_if.ctrl_we_i      = ctrl_we;
  assign dm_if.ctrl_wdata_i   = ctrl_wdata;
  assign dm_if.ctrl_wstat_i   = ctrl_wstat;
  assign dm_if.ctrl_tag_we_i  = ctrl_tag_we;
  assign dm_if.ctrl_valid_i   = ctrl_valid;
  assign dm_if.ctrl_invalid_i = ctrl_invalid;

  assign tw_if.invalidate_i   = invalidate;
  assign tw_if.host_addr_i    = host_addr;
  assign tw_if.host_re_i      = host_re;
  assign tw_if.ctrl_en_i      = ctrl_en;
  assign tw_if.ctrl_addr_i    = ctrl_addr;
  assign tw_if.ctrl_we_i      = ctrl_we;
  assign tw_if.ctrl_wdata_i   = ctrl_wdata;
  assign tw_if.ctrl_wstat_i   = ctrl_wstat;
  assign tw_if.ctrl_tag_we_i  = ctrl_tag_we;
  assign tw_if.ctrl_valid_i   = ctrl_valid;
  assign tw_if.ctrl_invalid_i = ctrl_invalid;

  cellrv32_icache_mem #(.ICACHE_NUM_BLOCKS(4), .ICACHE_BLOCK_SIZE(64), .ICACHE_NUM_SETS(1))
    u_dm (.clk_i(clk), .rst_i(rst), .bus(dm_if));

  cellrv32_icache_mem #(.ICACHE_NUM_BLOCKS(4), .ICACHE_BLOCK_SIZE(64), .ICACHE_NUM_SETS(2))
    u_tw (.clk_i(clk), .rst_i(rst), .bus(tw_if));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host lookup, check both instances, then one idle cycle so a hit can update replacement state.
  task automatic look(input string tag, input logic [31:0] addr,
                      input logic dm_hit, input logic [31:0] dm_data,
                      input logic tw_hit, input logic [31:0] tw_data, input logic stat);
    ctrl_en   = 1'b0;
    host_addr = addr;
    host_re   = 1'b1;
    tick();
    host_re = 1'b0;
    check({tag, "_dm_hit"}, 32'(dm_if.hit_o), 32'(dm_hit));
    if (dm_hit) begin
      check({tag, "_dm_data"}, dm_if.host_rdata_o, dm_data);
      check({tag, "_dm_stat"}, 32'(dm_if.host_rstat_o), 32'(stat));
    end
    check({tag, "_tw_hit"}, 32'(tw_if.hit_o), 32'(tw_hit));
    if (tw_hit) begin
      check({tag, "_tw_data"}, tw_if.host_rdata_o, tw_data);
      check({tag, "_tw_stat"}, 32'(tw_if.host_rstat_o), 32'(stat));
    end
    tick();
  endtask

  task automatic refill(input logic [31:0] base, input logic [31:0] data_base,
                        input int err_word, input logic with_inv);
    ctrl_en = 1'b1;
    for (int n = 0; n < 16; n++) begin
      ctrl_addr  = base + 32'(4 * n);
      ctrl_we    = 1'b1;
      ctrl_wdata = data_base + 32'(n);
      ctrl_wstat = (n == err_word);
      tick();
    end
    ctrl_we     = 1'b0;
    ctrl_wstat  = 1'b0;
    ctrl_tag_we = 1'b1;
    ctrl_valid  = 1'b1;
    invalidate  = with_inv;
    tick();
    ctrl_tag_we = 1'b0;
    ctrl_valid  = 1'b0;
    invalidate  = 1'b0;
    ctrl_en     = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_dm_hit", 32'(dm_if.hit_o), 32'h0);
    check("rst_dm_rdata", dm_if.host_rdata_o, 32'h0);
    check("rst_dm_rstat", 32'(dm_if.host_rstat_o), 32'h0);
    check("rst_tw_hit", 32'(tw_if.hit_o), 32'h0);
    look("rst_look", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Refill 0x100 with word 5 flagged as bus error.
    refill(32'h100, 32'hA0, 5, 1'b0);
    look("hit_108", 32'h108, 1'b1, 32'hA2, 1'b1, 32'hA2, 1'b0);
    look("err_114", 32'h114, 1'b1, 32'hA5, 1'b1, 32'hA5, 1'b1);
    look("byte_10b", 32'h10B, 1'b1, 32'hA2, 1'b1, 32'hA2, 1'b0);
    look("miss_208", 32'h208, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    look("inv_108", 32'h108, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    refill(32'h100, 32'hA0, -1, 1'b1);
    look("invval_108", 32'h108, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Two tags on index 0; the last host hit is on 0x100.
    refill(32'h100, 32'hA0, -1, 1'b0);
    refill(32'h200, 32'hB0, -1, 1'b0);
    look("conf_200", 32'h200, 1'b1, 32'hB0, 1'b1, 32'hB0, 1'b0);
    look("conf_100", 32'h100, 1'b0, 32'h0, 1'b1, 32'hA0, 1'b0);

    refill(32'h300, 32'hC0, -1, 1'b0);
    look("repl_300", 32'h300, 1'b1, 32'hC0, 1'b1, 32'hC0, 1'b0);
`ifdef CELLRV32_ICACHE_LRU_EN
    look("repl_100", 32'h100, 1'b0, 32'h0, 1'b1, 32'hA0, 1'b0);
    look("repl_200", 32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
`else
    look("repl_100", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look("repl_200", 32'h200, 1'b0, 32'h0, 1'b1, 32'hB0, 1'b0);
`endif

    // Reset in the middle of a refill of 0x400.
    ctrl_en = 1'b1;
    for (int n = 0; n < 4; n++) begin
      ctrl_addr  = 32'h400 + 32'(4 * n);
      ctrl_we    = 1'b1;
      ctrl_wdata = 32'hD0 + 32'(n);
      tick();
    end
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    ctrl_we = 1'b0;
    ctrl_en = 1'b0;
    look("mid_300", 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look("mid_400", 32'h404, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
